// File: rtl/tc_program_pkg.sv
// Shared state encoding and elaboration helpers for the program fetch unit.
package tc_program_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

    function automatic int unsigned bytes_per_word(input int unsigned bit_width);
        return bit_width / 8;
    endfunction

endpackage

// File: rtl/tc_byte_packer.sv
// Assembles little-endian program bytes into words; strobes a word when full or on the last byte.
module tc_byte_packer
    import tc_program_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic [7:0]           byte_i,
    input  logic                 last_i,
    output logic                 word_wr_o,
    output logic [BIT_WIDTH-1:0] word_o
);
    localparam int unsigned Bpw   = bytes_per_word(BIT_WIDTH);
    localparam int unsigned LaneW = (Bpw > 1) ? clog2(Bpw) : 1;

    logic [LaneW-1:0]     lane_q, lane_d;
    logic [BIT_WIDTH-1:0] buf_q, buf_d;
    logic [BIT_WIDTH-1:0] merged;
    logic                 lane_full;

    always_comb begin
        // buf_q only ever holds lower lanes, so a short final word is zero-padded for free
        merged    = buf_q | (BIT_WIDTH'(byte_i) << {lane_q, 3'b000});
        lane_full = (lane_q == LaneW'(Bpw - 1));
        word_wr_o = valid_i & (lane_full | last_i);
        word_o    = merged;
        lane_d    = lane_q;
        buf_d     = buf_q;
        if (clear_i) begin
            lane_d = '0;
            buf_d  = '0;
        end else if (valid_i) begin
            if (lane_full || last_i) begin
                lane_d = '0;
                buf_d  = '0;
            end else begin
                lane_d = lane_q + LaneW'(1);
                buf_d  = merged;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            buf_q  <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/tc_program_fetch.sv
// Program memory with a valid/ready byte loader and a registered multi-word fetch port.
module tc_program_fetch
    import tc_program_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned BIT_DEPTH = 256,
    parameter int unsigned NUM_OUT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [7:0]                   load_byte,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic                         load_done,
    input  logic [15:0]                  address,
    input  logic                         fetch_en,
    output logic [NUM_OUT*BIT_WIDTH-1:0] out,
    output logic                         out_valid
);
    localparam int unsigned AddrW = clog2(BIT_DEPTH);
    localparam int unsigned LenW  = AddrW + 1;
    localparam int unsigned OutW  = NUM_OUT * BIT_WIDTH;

    state_e               state_q, state_d;
    logic                 load_ready_q, load_ready_d;
    logic                 load_done_q, load_done_d;
    logic [AddrW-1:0]     wptr_q, wptr_d;
    logic [LenW-1:0]      prog_len_q, prog_len_d;
    logic [OutW-1:0]      out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0] mem_q [BIT_DEPTH];

    logic                 byte_accept;
    logic                 word_wr;
    logic                 last_word;
    logic                 load_end;
    logic [BIT_WIDTH-1:0] word_data;
    logic [AddrW-1:0]     base;
    logic [AddrW-1:0]     idx;
    logic [OutW-1:0]      fetch_data;
    logic                 unused_address;

    // load_start wins over a byte presented in the same cycle
    assign byte_accept = load_valid & load_ready_q & ~load_start;
    assign last_word   = word_wr & (wptr_q == AddrW'(BIT_DEPTH - 1));
    assign load_end    = byte_accept & (load_last | last_word);

    tc_byte_packer #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (load_start),
        .valid_i  (byte_accept),
        .byte_i   (load_byte),
        .last_i   (load_last),
        .word_wr_o(word_wr),
        .word_o   (word_data)
    );

    assign base           = address[AddrW-1:0];
    assign unused_address = ^address;

    // Words at or beyond prog_len read as zero, so stale contents never leak out
    always_comb begin
        fetch_data = '0;
        idx        = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            idx = base + AddrW'(k);
            if (LenW'(idx) < prog_len_q) begin
                fetch_data[k*BIT_WIDTH +: BIT_WIDTH] = mem_q[idx];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        prog_len_d  = prog_len_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        load_done_d = 1'b0;
        if (load_start) begin
            state_d    = StLoad;
            wptr_d     = '0;
            prog_len_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StLoad: begin
                    if (word_wr) begin
                        wptr_d     = wptr_q + AddrW'(1);
                        prog_len_d = LenW'(wptr_q) + LenW'(1);
                    end
                    if (load_end) begin
                        state_d     = StRun;
                        load_done_d = 1'b1;
                    end
                end
                StRun: begin
                    if (fetch_en) begin
                        out_d       = fetch_data;
                        out_valid_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        load_ready_d = (state_d == StLoad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            wptr_q       <= '0;
            prog_len_q   <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ready_q <= load_ready_d;
            load_done_q  <= load_done_d;
            wptr_q       <= wptr_d;
            prog_len_q   <= prog_len_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Storage is deliberately not reset; prog_len gating hides old contents
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem_q[wptr_q] <= word_data;
        end
    end

    assign load_ready = load_ready_q;
    assign load_done  = load_done_q;
    assign out        = out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_tc_program_fetch.sv
// Bench for tc_program_fetch: directed and random loads/fetches checked against a byte-list model.
module tb_tc_program_fetch;
    localparam int unsigned AW = 16;
    localparam int unsigned AD = 8;
    localparam int unsigned AN = 4;
    localparam int unsigned BW = 32;
    localparam int unsigned BD = 8;
    localparam int unsigned BN = 2;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             a_start, a_valid, a_last, a_ready, a_done, a_fetch, a_out_valid;
    logic [7:0]       a_byte;
    logic [15:0]      a_addr;
    logic [AN*AW-1:0] a_out;

    logic             b_start, b_valid, b_last, b_ready, b_done, b_fetch, b_out_valid;
    logic [7:0]       b_byte;
    logic [15:0]      b_addr;
    logic [BN*BW-1:0] b_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0]    ref_mem [AD];
    int               ref_len;
    logic [AN*AW-1:0] ref_out;
    logic [BW-1:0]    b_ref [BD];
    int               b_len;
    logic [BN*BW-1:0] b_exp;
    byte_q_t          q;
    int               n;

    tc_program_fetch #(
        .BIT_WIDTH(AW), .BIT_DEPTH(AD), .NUM_OUT(AN)
    ) dut_a (
        .clk(clk), .rst(rst), .load_start(a_start), .load_valid(a_valid),
        .load_byte(a_byte), .load_last(a_last), .load_ready(a_ready), .load_done(a_done),
        .address(a_addr), .fetch_en(a_fetch), .out(a_out), .out_valid(a_out_valid)
    );

    tc_program_fetch #(
        .BIT_WIDTH(BW), .BIT_DEPTH(BD), .NUM_OUT(BN)
    ) dut_b (
        .clk(clk), .rst(rst), .load_start(b_start), .load_valid(b_valid),
        .load_byte(b_byte), .load_last(b_last), .load_ready(b_ready), .load_done(b_done),
        .address(b_addr), .fetch_en(b_fetch), .out(b_out), .out_valid(b_out_valid)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Model: bytes pair up little-endian into words, capped at AD words
    task automatic model_load(input byte_q_t bytes);
        int cnt;
        cnt = bytes.size();
        if (cnt > 2 * AD) cnt = 2 * AD;
        ref_len = (cnt + 1) / 2;
        for (int i = 0; i < ref_len; i++) begin
            ref_mem[i] = {(2 * i + 1 < cnt) ? bytes[2 * i + 1] : 8'h00, bytes[2 * i]};
        end
    endtask

    function automatic logic [AN*AW-1:0] a_expect(input logic [15:0] addr);
        logic [AN*AW-1:0] r;
        r = '0;
        for (int k = 0; k < AN; k++) begin
            int wi;
            wi = (int'(addr) + k) % AD;
            if (wi < ref_len) r[k*AW +: AW] = ref_mem[wi];
        end
        return r;
    endfunction

    task automatic a_start_load();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_eq("ready_after_start", a_ready, 1);
    endtask

    task automatic a_send(input byte_q_t bytes, input bit gaps);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < bytes.size() && guard < 400) begin
            guard++;
            if (gaps && $urandom_range(0, 1) == 0) begin
                a_valid = 1'b0;
                @(negedge clk);
                continue;
            end
            a_valid = 1'b1;
            a_byte  = bytes[i];
            a_last  = (i == bytes.size() - 1);
            check_eq("ready_in_load", a_ready, 1);
            @(negedge clk);
            if (a_last || i == 2 * AD - 1) begin
                a_byte = 8'hEE;
                a_last = 1'b0;
                check_eq("load_done", a_done, 1);
                check_eq("ready_after_load", a_ready, 0);
                @(negedge clk);
                a_valid = 1'b0;
                check_eq("load_done_pulse", a_done, 0);
                return;
            end
            i++;
        end
        a_valid = 1'b0;
        check_eq("load_timeout", 0, 1);
    endtask

    task automatic a_fetch_chk(input logic [15:0] addr, input string tag);
        a_addr  = addr;
        a_fetch = 1'b1;
        @(negedge clk);
        a_fetch = 1'b0;
        ref_out = a_expect(addr);
        check_eq({tag, "_valid"}, a_out_valid, 1);
        check_eq({tag, "_out"}, a_out, ref_out);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {a_start, a_valid, a_last, a_fetch, b_start, b_valid, b_last, b_fetch} = '0;
        a_byte = '0; a_addr = '0; b_byte = '0; b_addr = '0;
        ref_len = 0; ref_out = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out", a_out, 0);
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_ready", a_ready, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_b_out", b_out, 0);
        rst = 1'b0;

        // Fetch while idle is ignored
        a_fetch = 1'b1;
        @(negedge clk);
        a_fetch = 1'b0;
        check_eq("idle_fetch_valid", a_out_valid, 0);
        check_eq("idle_ready", a_ready, 0);

        // Four full words
        q.delete();
        for (int i = 0; i < 4; i++) begin
            q.push_back(8'(i + 1));
            q.push_back(8'h00);
        end
        a_start_load();
        a_send(q, 1'b0);
        model_load(q);
        a_fetch_chk(16'd0, "t1");
        check_eq("t1_const", a_out, 64'h0004_0003_0002_0001);

        // Full depth: 18 bytes offered, only 16 taken
        q.delete();
        for (int i = 0; i < 9; i++) begin
            q.push_back(8'(i));
            q.push_back(8'h00);
        end
        a_start_load();
        a_send(q, 1'b1);
        model_load(q);
        a_fetch_chk(16'd6, "wrap");
        check_eq("wrap_const", a_out, 64'h0001_0000_0007_0006);
        a_fetch_chk(16'd14, "trunc");
        check_eq("trunc_const", a_out, 64'h0001_0000_0007_0006);
        @(negedge clk);
        check_eq("hold_valid", a_out_valid, 0);
        check_eq("hold_out", a_out, ref_out);

        // Reset in the middle of a load
        a_start_load();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            a_byte  = 8'(8'h30 + i);
            @(negedge clk);
        end
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_out", a_out, 0);
        check_eq("midrst_ready", a_ready, 0);
        check_eq("midrst_done", a_done, 0);
        @(negedge clk);
        rst = 1'b0;
        ref_len = 0;
        ref_out = '0;
        a_fetch = 1'b1;
        @(negedge clk);
        a_fetch = 1'b0;
        check_eq("midrst_fetch_valid", a_out_valid, 0);
        check_eq("midrst_ready_low", a_ready, 0);

        // Partial final word
        q.delete();
        q.push_back(8'hAA); q.push_back(8'hBB); q.push_back(8'hCC);
        a_start_load();
        a_send(q, 1'b0);
        model_load(q);
        a_fetch_chk(16'd1, "partial");
        check_eq("partial_const", a_out, 64'h0000_0000_0000_00CC);
        a_fetch_chk(16'd0, "partial0");

        // load_start and fetch_en together in RUN
        a_start = 1'b1; a_fetch = 1'b1; a_valid = 1'b1; a_byte = 8'h5A; a_last = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_fetch = 1'b0; a_valid = 1'b0; a_last = 1'b0;
        check_eq("restart_run_valid", a_out_valid, 0);
        check_eq("restart_run_hold", a_out, ref_out);
        check_eq("restart_run_ready", a_ready, 1);

        // Restart mid-load; the colliding byte must be dropped
        a_valid = 1'b1; a_byte = 8'h77; @(negedge clk);
        a_byte = 8'h66; @(negedge clk);
        a_start = 1'b1; a_byte = 8'h99; a_last = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_valid = 1'b0; a_last = 1'b0;
        check_eq("restart_load_ready", a_ready, 1);
        check_eq("restart_load_done", a_done, 0);
        q.delete();
        q.push_back(8'h33); q.push_back(8'h44);
        a_send(q, 1'b0);
        model_load(q);
        a_fetch_chk(16'd0, "restart");
        check_eq("restart_const", a_out, 64'h0000_0000_0000_4433);

        // Wide words, valid toggled every other cycle, back-to-back fetches
        q.delete();
        for (int j = 0; j < 12; j++) q.push_back(8'($urandom));
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check_eq("b_ready_start", b_ready, 1);
        for (int j = 0; j < 12; j++) begin
            b_valid = 1'b0;
            @(negedge clk);
            b_valid = 1'b1;
            b_byte  = q[j];
            b_last  = (j == 11);
            @(negedge clk);
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        check_eq("b_done", b_done, 1);
        @(negedge clk);
        check_eq("b_done_pulse", b_done, 0);
        for (int i = 0; i < BD; i++) b_ref[i] = '0;
        b_len = 3;
        for (int j = 0; j < 12; j++) b_ref[j / 4][(j % 4) * 8 +: 8] = q[j];
        for (int i = 0; i < 4; i++) begin
            b_addr  = 16'(i);
            b_fetch = 1'b1;
            @(negedge clk);
            b_exp = '0;
            for (int k = 0; k < BN; k++) begin
                if ((i + k) % BD < b_len) b_exp[k*BW +: BW] = b_ref[(i + k) % BD];
            end
            check_eq("b_valid", b_out_valid, 1);
            check_eq("b_out", b_out, b_exp);
        end
        b_fetch = 1'b0;

        // Random loads with gaps, then back-to-back random fetches
        for (int it = 0; it < 8; it++) begin
            q.delete();
            n = $urandom_range(1, 20);
            for (int j = 0; j < n; j++) q.push_back(8'($urandom));
            a_start_load();
            a_send(q, 1'b1);
            model_load(q);
            for (int j = 0; j < 4; j++) begin
                a_addr  = 16'($urandom);
                a_fetch = 1'b1;
                @(negedge clk);
                ref_out = a_expect(a_addr);
                check_eq("rnd_valid", a_out_valid, 1);
                check_eq("rnd_out", a_out, ref_out);
            end
            a_fetch = 1'b0;
            @(negedge clk);
            check_eq("rnd_hold_valid", a_out_valid, 0);
            check_eq("rnd_hold_out", a_out, ref_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tc_program_fetch.md
# tc_program_fetch

Parametrised program memory with a runtime byte-stream loader and a registered multi-word fetch port. Successor to the fixed four-output program ROM: width, depth and output-word count are parameters, the program is loaded over a valid/ready byte interface instead of at elaboration, and fetches are clocked with a valid flag. Sits between the host/testbench loader and the CPU instruction decoder.

## Interface

- BIT_WIDTH, 16, word width; one of 8, 16, 32, 64.
- BIT_DEPTH, 256, words of storage; power of two, 2..65536.
- NUM_OUT, 4, consecutive words returned per fetch; 1..8.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load_start  in  1  begin (or restart) a program load.
- load_valid  in  1  load_byte is valid.
- load_byte  in  8  program byte, little-endian within a word.
- load_last  in  1  marks the final byte of the program; qualified by load_valid.
- load_ready  out  1  loader accepts a byte this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- address  in  16  fetch base word address.
- fetch_en  in  1  request a fetch.
- out  out  NUM_OUT*BIT_WIDTH  word k in bits [k*BIT_WIDTH +: BIT_WIDTH].
- out_valid  out  1  out holds the result of the previous cycle's fetch.

## Operation

- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE: load_ready=0; fetch_en ignored. load_start -> LOAD.
- LOAD: load_ready=1. Byte/word pointers cleared on entry. Each accepted byte (load_valid & load_ready) fills the next byte lane; when BIT_WIDTH/8 lanes are full, the word is written at the word pointer and the pointer increments.
- Load ends on an accepted byte with load_last=1, or when word BIT_DEPTH-1 completes (further bytes not accepted). A partial final word is written with unfilled upper lanes zero. prog_len = number of words written. FSM -> RUN; load_done pulses in the cycle after the final byte is accepted.
- load_start in LOAD or RUN restarts the load (pointers cleared, prog_len=0); it takes priority over fetch_en and over a byte arriving in the same cycle, and that byte is not accepted.
- RUN: on fetch_en, for k in 0..NUM_OUT-1, idx_k = (address + k) mod BIT_DEPTH (address truncated to log2(BIT_DEPTH) bits, then wrapped); out word k = mem[idx_k] if idx_k < prog_len, else 0.
- Without fetch_en (or outside RUN), out holds and out_valid=0.
- Memory contents are not cleared by reset; prog_len gating makes unloaded words read as 0.

## Timing

- Reset values: out=0, out_valid=0, load_ready=0, load_done=0, prog_len=0, state IDLE.
- Fetch latency 1 cycle: fetch_en at edge N -> out/out_valid valid after edge N+1. Back-to-back fetches every cycle are supported.
- load_ready is a registered state decode: high from the cycle after load_start until the terminating byte is accepted.
- A word written at edge N is fetchable from edge N+1 (in RUN).
- rst mid-load: immediate return to IDLE, partial word discarded, prog_len=0.

## Structure

- Package tc_program_pkg: state enum (IDLE/LOAD/RUN), function bytes_per_word(BIT_WIDTH), function clog2 for pointer widths.
- Sub-module tc_byte_packer: byte-lane assembler (byte in, lane counter, word-complete strobe, zero-pad on last); the top holds FSM, storage and fetch datapath.

## Test plan

- Defaults; load bytes 01 00 02 00 03 00 04 00 (last on 8th) -> load_done pulse, prog_len=4; fetch address 0 -> out words 0001,0002,0003,0004, out_valid next cycle.
- Load 3 bytes AA BB CC (last on CC), BIT_WIDTH=16 -> words BBAA, 00CC; fetch address 1 -> 00CC,0000,0000,0000.
- BIT_DEPTH=8 fully loaded with words 0..7; fetch address 6 -> 0006,0007,0000,0001 (wrap); address 14 -> same result (truncation).
- Assert rst after 3 bytes of a load -> outputs 0, load_ready low next cycle, fetch in IDLE gives out_valid=0.
- In RUN, load_start and fetch_en same cycle -> no out_valid, FSM in LOAD, prior out held.
- BIT_WIDTH=32, NUM_OUT=2, load_valid toggled every other cycle -> words assembled correctly; fetch every cycle for 4 addresses -> 4 consecutive valid results.
